// File: rtl/recip_div_arbiter.sv
// recip_div_arbiter: shares one sequential fixed-point divider between the X
// and Y ray-setup requesters, computing 1.0 / b for deltaDist.
// Round-robin arbitration with a request/ack handshake. Zero divisors are
// answered without starting the divider, and divider overflow saturates.
// Optional build macro: RECIP_ABS_EN -- result is |1.0 / b| (deltaDist directly),
// with every saturation value forced to max positive.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no divide outstanding; arbitrate and accept requests
// WAIT   | divider running for the latched requester; requests ignored
module recip_div_arbiter #(
  parameter int WIDTH = 16,
  parameter int FBITS = 8
) (
  input  logic             pixel_clk_in,
  input  logic             rst_in,
  input  logic             req_x_in,
  input  logic             req_y_in,
  input  logic [WIDTH-1:0] b_x_in,
  input  logic [WIDTH-1:0] b_y_in,
  output logic             ack_x_out,
  output logic             ack_y_out,
  output logic             res_valid_out,
  output logic             res_id_out,
  output logic [WIDTH-1:0] res_out,
  output logic             res_dbz_out,
  output logic             busy_out,
  output logic             div_start_out,
  output logic [WIDTH-1:0] div_a_out,
  output logic [WIDTH-1:0] div_b_out,
  input  logic             div_busy_in,
  input  logic             div_done_in,
  input  logic             div_valid_in,
  input  logic             div_dbz_in,
  input  logic             div_ovf_in,
  input  logic [WIDTH-1:0] div_val_in
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam logic [WIDTH-1:0] ONE_FX  = {{(WIDTH-1){1'b0}}, 1'b1} << FBITS;
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [0:0]       state;
  logic             rr_ptr;
  logic             id_q;
  logic             sel;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] sat_val;
  logic [WIDTH-1:0] done_res;

  // The divider's own busy flag is redundant with our WAIT state.
  logic unused_div_busy;
  assign unused_div_busy = div_busy_in;

  // Numerator is always 1.0, independent of reset.
  assign div_a_out = ONE_FX;

  // Arbitration: a lone requester wins outright; on a conflict rr_ptr decides.
  always_comb begin
    sel = rr_ptr;
    if (req_x_in && !req_y_in) begin
      sel = 1'b0;
    end else if (req_y_in && !req_x_in) begin
      sel = 1'b1;
    end
    sel_b = sel ? b_y_in : b_x_in;
  end

  // Result formatting for a completed divide; div_b_out still holds the divisor.
  always_comb begin
`ifdef RECIP_ABS_EN
    sat_val = SAT_POS;
    if (div_ovf_in || div_dbz_in || !div_valid_in) begin
      done_res = sat_val;
    end else if (div_val_in == SAT_NEG) begin
      done_res = SAT_POS;
    end else if (div_val_in[WIDTH-1]) begin
      done_res = -div_val_in;
    end else begin
      done_res = div_val_in;
    end
`else
    sat_val = div_b_out[WIDTH-1] ? SAT_NEG : SAT_POS;
    if (div_ovf_in || div_dbz_in || !div_valid_in) begin
      done_res = sat_val;
    end else begin
      done_res = div_val_in;
    end
`endif
  end

  // Control FSM with registered handshakes and result outputs.
  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= S_IDLE;
      rr_ptr        <= 1'b0;
      id_q          <= 1'b0;
      ack_x_out     <= 1'b0;
      ack_y_out     <= 1'b0;
      div_start_out <= 1'b0;
      res_valid_out <= 1'b0;
      res_dbz_out   <= 1'b0;
      res_id_out    <= 1'b0;
      busy_out      <= 1'b0;
      res_out       <= '0;
      div_b_out     <= '0;
    end else begin
      ack_x_out     <= 1'b0;
      ack_y_out     <= 1'b0;
      div_start_out <= 1'b0;
      res_valid_out <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_x_in || req_y_in) begin
            rr_ptr <= ~sel;
            if (sel) begin
              ack_y_out <= 1'b1;
            end else begin
              ack_x_out <= 1'b1;
            end
            if (sel_b == '0) begin
              // Divide by zero answered immediately, divider untouched.
              res_valid_out <= 1'b1;
              res_dbz_out   <= 1'b1;
              res_out       <= SAT_POS;
              res_id_out    <= sel;
            end else begin
              div_start_out <= 1'b1;
              div_b_out     <= sel_b;
              id_q          <= sel;
              busy_out      <= 1'b1;
              state         <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (div_done_in) begin
            res_out       <= done_res;
            res_dbz_out   <= div_dbz_in;
            res_id_out    <= id_q;
            res_valid_out <= 1'b1;
            busy_out      <= 1'b0;
            state         <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_recip_div_arbiter.sv
// Bench for recip_div_arbiter: directed and random requests, a stand-in
// divider driven from the stimulus sequence, and an arithmetic reference
// for the expected reciprocal.
module tb_recip_div_arbiter;

  logic        pixel_clk_in = 1'b0;
  logic        rst_in;
  logic        req_x_in, req_y_in;
  logic [15:0] b_x_in, b_y_in;
  logic        ack_x_out, ack_y_out;
  logic        res_valid_out, res_id_out, res_dbz_out, busy_out;
  logic [15:0] res_out;
  logic        div_start_out;
  logic [15:0] div_a_out, div_b_out;
  logic        div_busy_in, div_done_in, div_valid_in, div_dbz_in, div_ovf_in;
  logic [15:0] div_val_in;

  int tests = 0;
  int fails = 0;

  recip_div_arbiter #(.WIDTH(16), .FBITS(8)) dut (
    .pixel_clk_in (pixel_clk_in),
    .rst_in       (rst_in),
    .req_x_in     (req_x_in),
    .req_y_in     (req_y_in),
    .b_x_in       (b_x_in),
    .b_y_in       (b_y_in),
    .ack_x_out    (ack_x_out),
    .ack_y_out    (ack_y_out),
    .res_valid_out(res_valid_out),
    .res_id_out   (res_id_out),
    .res_out      (res_out),
    .res_dbz_out  (res_dbz_out),
    .busy_out     (busy_out),
    .div_start_out(div_start_out),
    .div_a_out    (div_a_out),
    .div_b_out    (div_b_out),
    .div_busy_in  (div_busy_in),
    .div_done_in  (div_done_in),
    .div_valid_in (div_valid_in),
    .div_dbz_in   (div_dbz_in),
    .div_ovf_in   (div_ovf_in),
    .div_val_in   (div_val_in)
  );

  always #5 pixel_clk_in = ~pixel_clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: 1.0/b in Q8.8 is 65536/b truncated toward zero, then saturated.
  function automatic logic [15:0] ref_recip(input logic [15:0] b, input int force_mode);
    int bi;
    int q;
    logic [15:0] r;
    bi = int'($signed(b));
    if (bi == 0) return 16'h7FFF;
`ifdef RECIP_ABS_EN
    if (force_mode != 0) return 16'h7FFF;
    q = 65536 / bi;
    if (q < 0) q = -q;
    if (q > 32767) return 16'h7FFF;
    r = q[15:0];
    return r;
`else
    if (force_mode != 0) return (bi >= 0) ? 16'h7FFF : 16'h8000;
    q = 65536 / bi;
    if (q > 32767) return 16'h7FFF;
    if (q < -32768) return 16'h8000;
    r = q[15:0];
    return r;
`endif
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack_x"}, ack_x_out, 0);
    chk({tag, "_ack_y"}, ack_y_out, 0);
    chk({tag, "_start"}, div_start_out, 0);
    chk({tag, "_valid"}, res_valid_out, 0);
    chk({tag, "_dbz"}, res_dbz_out, 0);
    chk({tag, "_id"}, res_id_out, 0);
    chk({tag, "_busy"}, busy_out, 0);
    chk({tag, "_res"}, res_out, 0);
    chk({tag, "_div_b"}, div_b_out, 0);
    chk({tag, "_div_a"}, div_a_out, 16'h0100);
  endtask

  task automatic wait_ack(output logic got);
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge pixel_clk_in);
      if (ack_x_out || ack_y_out) begin
        got = 1'b1;
        return;
      end
    end
    chk("ack_timeout", ack_x_out | ack_y_out, 1);
  endtask

  // Called at the negedge where the ack is visible; plays the divider role.
  task automatic serve(input logic id, input logic [15:0] b, input int force_mode, input int lat);
    int bi;
    int q;
    logic [15:0] exp_res;
    exp_res = ref_recip(b, force_mode);
    chk("ack_sel", {ack_y_out, ack_x_out}, id ? 2'b10 : 2'b01);
    chk("two_acks", ack_x_out & ack_y_out, 0);
    if (b == 16'h0000) begin
      chk("zero_start", div_start_out, 0);
      chk("zero_valid", res_valid_out, 1);
      chk("zero_res", res_out, exp_res);
      chk("zero_dbz", res_dbz_out, 1);
      chk("zero_id", res_id_out, id);
      chk("zero_busy", busy_out, 0);
      @(negedge pixel_clk_in);
      chk("zero_start_after", div_start_out, 0);
      chk("zero_valid_after", res_valid_out, 0);
      chk("zero_res_hold", res_out, exp_res);
    end else begin
      chk("start", div_start_out, 1);
      chk("div_b", div_b_out, b);
      chk("busy", busy_out, 1);
      chk("early_valid", res_valid_out, 0);
      bi = int'($signed(b));
      q = 65536 / bi;
      repeat (lat) begin
        @(negedge pixel_clk_in);
        chk("wait_no_valid", res_valid_out, 0);
      end
      div_done_in  = 1'b1;
      div_val_in   = q[15:0];
      div_valid_in = (force_mode != 2);
      div_ovf_in   = (q > 32767) || (q < -32768) || (force_mode == 1);
      @(negedge pixel_clk_in);
      div_done_in  = 1'b0;
      div_valid_in = 1'b0;
      div_ovf_in   = 1'b0;
      chk("res_valid", res_valid_out, 1);
      chk("res_val", res_out, exp_res);
      chk("res_dbz", res_dbz_out, 0);
      chk("res_id", res_id_out, id);
      chk("res_busy", busy_out, 0);
    end
  endtask

  // One requester alone; request dropped as soon as the ack is seen.
  task automatic req1(input logic id, input logic [15:0] b, input int force_mode, input int lat);
    logic got;
    if (id) begin
      b_y_in = b; req_y_in = 1'b1;
    end else begin
      b_x_in = b; req_x_in = 1'b1;
    end
    wait_ack(got);
    req_x_in = 1'b0;
    req_y_in = 1'b0;
    if (got) serve(id, b, force_mode, lat);
  endtask

  initial begin
    logic got;
    logic [15:0] rb;
    int r;
    rst_in = 1'b0;
    req_x_in = 1'b0; req_y_in = 1'b0;
    b_x_in = '0; b_y_in = '0;
    div_busy_in = 1'b0; div_done_in = 1'b0; div_valid_in = 1'b0;
    div_dbz_in = 1'b0; div_ovf_in = 1'b0; div_val_in = '0;
    repeat (3) @(negedge pixel_clk_in);
    chk_reset_vals("rst");
    rst_in = 1'b1;

    // Both requests held from reset: X, Y, X, Y.
    b_x_in = 16'h0200; b_y_in = 16'h0300;
    req_x_in = 1'b1; req_y_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(got);
      if (got) serve(k[0], k[0] ? 16'h0300 : 16'h0200, 0, $urandom_range(0, 3));
    end
    req_x_in = 1'b0; req_y_in = 1'b0;
    @(negedge pixel_clk_in);

    // Directed plan cases.
    req1(1'b0, 16'h0200, 0, 2);
    req1(1'b1, 16'hFE00, 0, 1);
    req1(1'b0, 16'h0000, 0, 0);
    req1(1'b0, 16'h0001, 0, 3);
    req1(1'b0, 16'hFFFF, 0, 0);
    req1(1'b1, 16'h0100, 2, 1);
    req1(1'b1, 16'hFF00, 1, 2);

    // Reset three cycles into WAIT; X accept leaves rr_ptr pointing at Y.
    b_x_in = 16'h0400; req_x_in = 1'b1;
    wait_ack(got);
    req_x_in = 1'b0;
    repeat (3) @(negedge pixel_clk_in);
    chk("midwait_busy", busy_out, 1);
    rst_in = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge pixel_clk_in);
    rst_in = 1'b1;
    div_done_in = 1'b1; div_valid_in = 1'b1; div_val_in = 16'h1234;
    @(negedge pixel_clk_in);
    div_done_in = 1'b0; div_valid_in = 1'b0;
    chk("stray_done_valid", res_valid_out, 0);
    chk("stray_done_res", res_out, 0);
    b_x_in = 16'h0080; b_y_in = 16'h0040;
    req_x_in = 1'b1; req_y_in = 1'b1;
    wait_ack(got);
    req_x_in = 1'b0; req_y_in = 1'b0;
    if (got) serve(1'b0, 16'h0080, 0, 1);

    // Random single requests against the reference.
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 7);
      if (r == 0) rb = 16'h0000;
      else if (r == 1) rb = ($urandom_range(0, 1) != 0) ? 16'(-$urandom_range(1, 3)) : 16'($urandom_range(1, 3));
      else rb = 16'($urandom);
      r = $urandom_range(0, 5);
      req1(1'($urandom_range(0, 1)), rb, (r == 4) ? 1 : ((r == 5) ? 2 : 0), $urandom_range(0, 4));
    end

    @(negedge pixel_clk_in);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/recip_div_arbiter.md
# recip_div_arbiter

Shares one sequential fixed-point `divider` instance (a / b, `WIDTH`/`FBITS`) between the X and Y ray-setup requesters. Each request computes the reciprocal 1.0 / b used for deltaDist. Round-robin arbitration and request/ack handshakes are used. Zero divisors are short-circuited and overflow is saturated. The block sits between the per-column ray-setup logic and the single divider, replacing one private divider per axis.

## Interface
- `WIDTH`, 16, operand/result width (signed two's complement)
- `FBITS`, 8, fractional bits; 1.0 = `1 << FBITS` (0x0100)
- `pixel_clk_in` in 1: sole clock, all flops on rising edge
- `rst_in` in 1: asynchronous, active-low reset
- `req_x_in`, `req_y_in` in 1: request; held high until the matching ack
- `b_x_in`, `b_y_in` in `WIDTH`: signed divisor (rayDirX / rayDirY), stable while req is high
- `ack_x_out`, `ack_y_out` out 1: one-cycle pulse, request accepted
- `res_valid_out` out 1: one-cycle pulse, result available
- `res_id_out` out 1: requester owning the result (0 = X, 1 = Y)
- `res_out` out `WIDTH`: reciprocal result
- `res_dbz_out` out 1: divisor was zero
- `busy_out` out 1: divider transaction outstanding
- `div_start_out` out 1: one-cycle start pulse to the divider
- `div_a_out` out `WIDTH`: constant 1.0
- `div_b_out` out `WIDTH`: latched divisor
- `div_busy_in`, `div_done_in`, `div_valid_in`, `div_dbz_in`, `div_ovf_in` in 1: divider status
- `div_val_in` in `WIDTH`: divider quotient

## Operation
- States: IDLE, WAIT.
- `rr_ptr` (1 bit) names the requester that has priority on the next conflict. Reset value is 0 (X).
- IDLE, no request: hold.
- IDLE, one or more requests: select one.
  - If only one requester is high, select it.
  - If both are high, select `rr_ptr`. Set `rr_ptr` to the unselected id.
  - If only one is high, set `rr_ptr` to the other id.
- Accept with selected b != 0:
  - `ack_<sel>` = 1; `div_start_out` = 1; `div_b_out` = b; latch id; `busy_out` = 1.
  - Go to WAIT.
- Accept with selected b == 0:
  - Divider is not started.
  - `ack_<sel>` = 1 and `res_valid_out` = 1 in the same cycle.
  - `res_dbz_out` = 1; `res_out` = 0x7FFF (max positive).
  - Stay in IDLE.
- WAIT: ignore `req_*`. On `div_done_in`:
  - If `div_ovf_in`, `div_dbz_in` or !`div_valid_in`: `res_out` = saturated value. Saturated value is 0x7FFF if latched b ≥ 0, else 0x8000.
  - Otherwise `res_out` = `div_val_in`.
  - `res_dbz_out` = `div_dbz_in`; `res_id_out` = latched id; `res_valid_out` = 1; `busy_out` = 0.
  - Go to IDLE.
- `div_done_in` outside WAIT is ignored.
- `div_a_out` is constant 1.0 at all times, including during reset.
- Requester contract:
  - Dropping req before ack is permitted; the request is withdrawn.
  - Requester must not change b while req is high.

## Timing
- All outputs are registered.
- Reset values:
  - state = IDLE, `rr_ptr` = 0.
  - All acks, `div_start_out`, `res_valid_out`, `res_dbz_out`, `res_id_out`, `busy_out` = 0.
  - `res_out` = 0, `div_b_out` = 0.
- Request sampled at edge E0: ack and `div_start_out` are high for exactly the cycle after E0.
- `div_done_in` sampled at edge En: `res_valid_out` is high the cycle after En.
- The next request can be sampled at edge En+1, so back-to-back X/Y requests alternate with no idle gap beyond that cycle.
- Zero-divisor path: ack-to-result latency is 0 cycles (same cycle). The next accept is possible at E0+1.
- `res_out`, `res_id_out` and `res_dbz_out` hold until the next `res_valid_out`.
- Reset asserted mid-WAIT: the block returns to IDLE immediately and no result is issued. The integrator resets the divider from the same reset.

## Configuration
- `RECIP_ABS_EN` defined:
  - `res_out` = |quotient|; 0x8000 maps to 0x7FFF.
  - All saturation values are 0x7FFF.
  - Output is deltaDist directly.
- `RECIP_ABS_EN` undefined: signed quotient, saturation as in Operation.

## Test plan
- X alone, b = 0x0200 (2.0); divider model returns 0x0080:
  - `ack_x_out` pulse, then `res_valid_out`, `res_id_out` = 0, `res_out` = 0x0080, `res_dbz_out` = 0.
- Y alone, b = 0xFE00 (-2.0):
  - Without the macro, `res_out` = 0xFF80.
  - With `RECIP_ABS_EN`, `res_out` = 0x0080.
- Both requests high from reset, held continuously:
  - Service order X, Y, X, Y.
  - Exactly one ack per accept; never two acks in the same cycle.
- X with b = 0x0000:
  - `ack_x_out` and `res_valid_out` in the same cycle, `res_out` = 0x7FFF, `res_dbz_out` = 1.
  - `div_start_out` never asserted.
- X with b = 0x0001; model asserts `div_ovf_in`:
  - `res_out` = 0x7FFF.
  - With b = 0xFFFF and the macro undefined, `res_out` = 0x8000.
- Reset pulled low 3 cycles into WAIT, then released:
  - All outputs return to reset values; no `res_valid_out`.
  - Next request served normally with X priority.
